// File: rtl/muldiv_unit.sv
// Sequential multiply/divide unit with architectural HI/LO registers.
// Signed and unsigned MULT/DIV with MIPS semantics, one bit per cycle.
// Shift-add multiply and restoring divide both work on operand magnitudes.
// A FIX cycle then applies the result signs and writes HI/LO.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_res;   // quotient/product sign differs from magnitude
  logic               neg_rem;   // dividend was negative
  logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc;       // {upper, lower}: product, or {rem, quo}

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_up;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;
  logic               mtx_ok;    // MTHI/MTLO may be applied this cycle

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic en);
    cond_neg = en ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v,
                                                   input logic en);
    cond_neg2 = en ? -v : v;
  endfunction

  // Magnitude of a two's complement value when the op is signed.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v,
                                           input logic is_signed);
    mag = cond_neg(v, is_signed & v[WIDTH-1]);
  endfunction

  // One shift-add step and one restoring-divide step, computed every cycle.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]}
                      : {1'b0, acc[2*WIDTH-1:1]};
    div_up   = acc[2*WIDTH-1:WIDTH-1];
    div_ok   = (div_up >= {1'b0, opnd});
    div_rem  = div_up[WIDTH-1:0] - opnd;
    div_next = div_ok ? {div_rem, acc[WIDTH-2:0], 1'b1}
                      : {acc[2*WIDTH-2:0], 1'b0};
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic: IDLE -> RUN -> FIX -> DONE -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN:  if (cnt == '0) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // An accepted start wins over a same-cycle MTHI/MTLO.
  assign mtx_ok = ((state == S_IDLE) && !start) || (state == S_DONE);

  // Operand latch, iteration, sign fix-up and HI/LO writes.
  always_ff @(posedge Clk) begin
    if (reset) begin
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      opnd        <= '0;
      acc         <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (mtx_ok) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            is_div      <= op[1];
            neg_res     <= ~op[0] & (lhs[WIDTH-1] ^ rhs[WIDTH-1]);
            neg_rem     <= ~op[0] & lhs[WIDTH-1];
            div_by_zero <= 1'b0;
            cnt         <= CNT_W'(WIDTH);
            if (op[1]) begin
              opnd <= mag(rhs, ~op[0]);
              acc  <= {{WIDTH{1'b0}}, mag(lhs, ~op[0])};
            end else begin
              opnd <= mag(lhs, ~op[0]);
              acc  <= {{WIDTH{1'b0}}, mag(rhs, ~op[0])};
            end
          end
        end
        S_RUN: begin
          if (cnt != '0) begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_FIX: begin
          if (is_div) begin
            // A zero divisor leaves rem = |dividend| (restored to lhs by the
            // sign fix) and forces an all-ones quotient.
            lo          <= (opnd == '0) ? {WIDTH{1'b1}}
                                        : cond_neg(acc[WIDTH-1:0], neg_res);
            hi          <= cond_neg(acc[2*WIDTH-1:WIDTH], neg_rem);
            div_by_zero <= (opnd == '0);
          end else begin
            {hi, lo} <= cond_neg2(acc, neg_res);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == S_RUN) || (state == S_FIX);
  assign done = (state == S_DONE);

endmodule
